// File: rtl/led_pattern_source.sv
// Pattern generator feeding the 4-bit LED register: ticked pattern advance,
// debounced button for mode select, and a one-cycle load strobe on every write.
module led_pattern_source #(
    parameter int TICK_BITS     = 22,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic       clk_in,
    input  logic       rstn,
    input  logic       btn,
    output logic [3:0] din,
    output logic       load,
    output logic [1:0] mode
);

    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_SHIFT  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_TOGGLE = 2'd3;
    localparam logic       DIR_LEFT    = 1'b0;
    localparam logic       DIR_RIGHT   = 1'b1;

    logic                     r_s1;
    logic                     r_s2;
    logic                     r_stable;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    logic [TICK_BITS-1:0]     r_tick_cnt;
    logic [3:0]               r_din;
    logic                     r_load;
    logic [1:0]               r_mode;
    logic                     r_dir;

    logic                     w_db_diff;
    logic                     w_db_done;
    logic                     w_press;
    logic                     w_tick;
    logic [1:0]               w_next_mode;
    logic [3:0]               w_seed;
    logic [3:0]               w_adv;
    logic                     w_adv_dir;

    assign w_db_diff   = (r_s2 != r_stable);
    assign w_db_done   = w_db_diff && (&r_db_cnt);
    // Only a rising stable level is a press; a release just updates stable.
    assign w_press     = w_db_done && r_s2;
    assign w_tick      = &r_tick_cnt;
    assign w_next_mode = r_mode + 2'd1;

    always_comb begin
        w_seed = 4'b0000;
        case (w_next_mode)
            MODE_COUNT:  w_seed = 4'b0000;
            MODE_SHIFT:  w_seed = 4'b0001;
            MODE_BOUNCE: w_seed = 4'b0001;
            MODE_TOGGLE: w_seed = 4'b0101;
            default:     w_seed = 4'b0000;
        endcase
    end

    always_comb begin
        w_adv     = r_din;
        w_adv_dir = r_dir;
        case (r_mode)
            MODE_COUNT: w_adv = r_din + 4'd1;
            MODE_SHIFT: w_adv = {r_din[2:0], r_din[3]};
            MODE_BOUNCE: begin
                // The end positions reflect back one step rather than stalling.
                if (r_dir == DIR_LEFT) begin
                    if (r_din == 4'b1000) begin
                        w_adv     = 4'b0100;
                        w_adv_dir = DIR_RIGHT;
                    end else begin
                        w_adv = {r_din[2:0], 1'b0};
                    end
                end else begin
                    if (r_din == 4'b0001) begin
                        w_adv     = 4'b0010;
                        w_adv_dir = DIR_LEFT;
                    end else begin
                        w_adv = {1'b0, r_din[3:1]};
                    end
                end
            end
            MODE_TOGGLE: w_adv = ~r_din;
            default:     w_adv = r_din;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_db_cnt   <= '0;
            r_tick_cnt <= '0;
            r_din      <= 4'b0000;
            r_load     <= 1'b0;
            r_mode     <= MODE_COUNT;
            r_dir      <= DIR_LEFT;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;

            if (w_db_done) begin
                r_stable <= r_s2;
                r_db_cnt <= '0;
            end else if (w_db_diff) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else begin
                r_db_cnt <= '0;
            end

            r_load <= w_press | w_tick;

            // A press wins over a coincident tick and restarts the tick period.
            if (w_press) begin
                r_mode     <= w_next_mode;
                r_din      <= w_seed;
                r_dir      <= DIR_LEFT;
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
                if (w_tick) begin
                    r_din <= w_adv;
                    r_dir <= w_adv_dir;
                end
            end
        end
    end

    assign din  = r_din;
    assign load = r_load;
    assign mode = r_mode;

endmodule
